ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the send side of the keyboard link, alongside the existing PS/2 receiver.
//  Sends one command byte from the core (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Uses the inhibit / request-to-send / device-clocked bit sequence and checks the device ACK.
//  Drives the open-collector lines through active-high pull-low enables; top level ties them to tristate pads.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before request (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles from tx_start to ACK (20 ms @ 50 MHz); counter width derived by $clog2
// PORTS
//  clk          in   1  system clock; sole clock domain
//  rst          in   1  synchronous reset, active-high
//  tx_data      in   8  command byte, sampled on the cycle tx_start is accepted
//  tx_start     in   1  1-cycle request; accepted only when busy==0
//  ps2_clk_in   in   1  ps2_clk pad input (asynchronous)
//  ps2_data_in  in   1  ps2_data pad input (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  busy         out  1  high from the cycle after acceptance until the cycle done pulses
//  done         out  1  1-cycle pulse at the end of every transfer
//  ack_err      out  1  valid with done; 1 = NACK or timeout; held until next acceptance
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; both lines released. Takes effect the cycle after rst, even mid-transfer; no done pulse.
//  Sync: ps2_clk_in and ps2_data_in each pass through 2 flip-flops. fall = (prev_sync_clk==1 && sync_clk==0).
//  Frame latch on accept: shreg[10:0] = {1'b1 stop, ~^tx_data odd parity, tx_data}.
//   Bit 0 of shreg (tx_data[0]) goes out first.
//  FSM:
//   IDLE: outputs released.
//    On tx_start: latch frame, clear bitcnt and timers, set busy, go to INHIBIT.
//   INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles: ps2_data_oe=1 (start bit 0), go to REQ.
//   REQ: hold ps2_data_oe=1 and ps2_clk_oe=1 for one cycle, then ps2_clk_oe=0; go to SEND.
//   SEND: on each fall:
//    - ps2_data_oe = ~shreg[0], shift shreg right, bitcnt++.
//    - Order: d0..d7, parity, stop (stop releases data). Data changes only while ps2_clk is low.
//    - The fall that makes bitcnt==10 places the stop bit; go to ACK.
//   ACK: data released. On next fall sample sync_data: 0 = ACK (ack_err=0), 1 = NACK (ack_err=1). Go to FIN.
//   FIN: wait until sync_clk==1 and sync_data==1 (lines idle), then pulse done, clear busy, go to IDLE.
//  Timeout: counter runs in every non-IDLE state.
//   Reaching TIMEOUT_CYCLES: release both lines, ack_err=1, pulse done, go to IDLE.
//   Timeout has priority over a fall in the same cycle.
//  tx_start while busy: ignored, no queueing.
//   tx_start on the same cycle as done: ignored; the core must retry once busy==0.
//  Falls seen in IDLE/INHIBIT (device-sent traffic): ignored; do not advance bitcnt.
// TESTING
//  Send 0xED; device model clocks at 12.5 kHz and ACKs.
//   -> data bits on falls: 1,0,1,1,0,1,1,1; parity 1; stop 1.
//   -> done pulses once, ack_err=0, busy low afterwards.
//  Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0; all with ack_err=0.
//  Inhibit timing: ps2_clk_oe high exactly INHIBIT_CYCLES cycles before ps2_data_oe rises.
//   -> No ps2_data_oe change while sync_clk is high in SEND.
//  Device model holds data high at the ACK fall -> done with ack_err=1.
//  Device never clocks -> done with ack_err=1 after TIMEOUT_CYCLES.
//   -> Both lines released; a second tx_start is then accepted.
//  Assert rst at bit 4 of SEND -> next cycle both oe=0, busy=0, no done.
//   -> A new 0xF4 transfer afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one command byte out on device clock falls and checks the ACK.
// Lines are driven through active-high pull-low enables; a timeout aborts any transfer that stalls.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, FIN} state_t;

   state_t        state, state_n;
   logic [10:0]   shreg, shreg_n;
   logic [3:0]    bitcnt, bitcnt_n;
   logic [IW-1:0] inh_cnt, inh_cnt_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic          clk_oe_n, data_oe_n, busy_n, done_n, ack_err_n;

   logic clk_s1, sync_clk, prev_sync_clk;
   logic data_s1, sync_data;
   logic fall, timeout;

   // Idle lines are high, so the synchronisers reset to 1 to avoid a phantom fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1        <= 1'b1;
         sync_clk      <= 1'b1;
         prev_sync_clk <= 1'b1;
         data_s1       <= 1'b1;
         sync_data     <= 1'b1;
      end else begin
         clk_s1        <= ps2_clk_in;
         sync_clk      <= clk_s1;
         prev_sync_clk <= sync_clk;
         data_s1       <= ps2_data_in;
         sync_data     <= data_s1;
      end
   end

   assign fall    = prev_sync_clk & ~sync_clk;
   assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ack_err     <= 1'b0;
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         bitcnt      <= bitcnt_n;
         inh_cnt     <= inh_cnt_n;
         to_cnt      <= to_cnt_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         busy        <= busy_n;
         done        <= done_n;
         ack_err     <= ack_err_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bitcnt_n  = bitcnt;
      inh_cnt_n = inh_cnt;
      to_cnt_n  = to_cnt;
      clk_oe_n  = ps2_clk_oe;
      data_oe_n = ps2_data_oe;
      busy_n    = busy;
      done_n    = 1'b0;
      ack_err_n = ack_err;

      if (state != IDLE)
         to_cnt_n = to_cnt + TW'(1);

      if (timeout) begin
         clk_oe_n  = 1'b0;
         data_oe_n = 1'b0;
         ack_err_n = 1'b1;
         done_n    = 1'b1;
         busy_n    = 1'b0;
         state_n   = IDLE;
      end else begin
         case (state)
            IDLE: begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               // A request coinciding with done is dropped; the core retries once busy is low.
               if (tx_start && !done) begin
                  shreg_n   = {1'b0, 1'b1, ~^tx_data, tx_data};
                  bitcnt_n  = '0;
                  inh_cnt_n = '0;
                  to_cnt_n  = '0;
                  busy_n    = 1'b1;
                  ack_err_n = 1'b0;
                  clk_oe_n  = 1'b1;
                  state_n   = INHIBIT;
               end
            end
            INHIBIT: begin
               clk_oe_n  = 1'b1;
               inh_cnt_n = inh_cnt + IW'(1);
               if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                  data_oe_n = 1'b1;
                  state_n   = REQ;
               end
            end
            REQ: begin
               clk_oe_n = 1'b0;
               state_n  = SEND;
            end
            SEND: begin
               if (fall) begin
                  data_oe_n = ~shreg[0];
                  shreg_n   = shreg >> 1;
                  bitcnt_n  = bitcnt + 4'd1;
                  if (bitcnt == 4'd9)
                     state_n = ACK;
               end
            end
            ACK: begin
               data_oe_n = 1'b0;
               if (fall) begin
                  ack_err_n = sync_data;
                  state_n   = FIN;
               end
            end
            FIN: begin
               if (sync_clk && sync_data) begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector line model plus a behavioural keyboard that clocks frames, records bits and ACKs or NACKs.
module tb_ps2_host_tx;
   localparam int INH = 40;
   localparam int TMO = 3000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int viol = 0;
   logic watch = 1'b0;
   logic prev_doe = 1'b0;

   always #10 clk = ~clk;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .busy(busy), .done(done), .ack_err(ack_err)
   );

   // The host may only move data while the line clock is low.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (watch && (ps2_data_oe !== prev_doe) && ps2_clk_in) viol++;
      prev_doe = ps2_data_oe;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_tx(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      cyc(1);
      tx_start = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   // Full transfer; abort_at >= 0 pulses rst after that many device clock falls.
   task automatic run_frame(input logic [7:0] d, input bit ack, input bit dup,
                            input bit retry, input int abort_at);
      int n;
      int h;
      int d0;
      logic [9:0] exp_bits;
      logic [9:0] got;
      for (int i = 0; i < 8; i++) exp_bits[i] = d[i];
      exp_bits[8] = ($countones(d) % 2 == 0);
      exp_bits[9] = 1'b1;
      got = '0;
      h   = $urandom_range(20, 40);
      d0  = done_cnt;
      viol = 0;
      start_tx(d);
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < 10 * INH) begin
         n++;
         tx_start = dup && (n == 1);
         tx_data  = ~d;
         cyc(1);
      end
      tx_start = 1'b0;
      chk("inhibit_cycles", n, INH);
      n = 0;
      while (ps2_clk_oe && n < 10) begin
         n++;
         cyc(1);
      end
      chk("req_clk_released", ps2_clk_oe, 0);
      chk("req_start_bit", ps2_data_oe, 1);
      watch = 1'b1;
      cyc(5);
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         cyc(h);
         if (i == abort_at - 1) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
            chk("rst_clk_oe", ps2_clk_oe, 0);
            chk("rst_data_oe", ps2_data_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            watch = 1'b0;
            dev_clk_low = 1'b0;
            cyc(100);
            chk("rst_no_done", done_cnt - d0, 0);
            chk("rst_idle_busy", busy, 0);
            return;
         end
         dev_clk_low = 1'b0;
         got[i] = ps2_data_in;
         cyc(h);
      end
      watch = 1'b0;
      chk("frame_bits", int'(got), int'(exp_bits));
      chk("data_while_clk_high", viol, 0);
      chk("data_released_before_ack", ps2_data_oe, 0);
      dev_data_low = ack;
      cyc(h);
      dev_clk_low = 1'b1;
      cyc(h);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      n = 0;
      while (!done && n < 300) begin
         n++;
         cyc(1);
      end
      chk("done_seen", done, 1);
      chk("ack_err", ack_err, ack ? 0 : 1);
      if (retry) begin
         tx_data  = 8'h55;
         tx_start = 1'b1;
         cyc(1);
         tx_start = 1'b0;
         chk("start_on_done_ignored", busy, 0);
      end else begin
         cyc(1);
         chk("busy_after_done", busy, 0);
      end
      cyc(INH + 5);
      chk("done_once", done_cnt - d0, 1);
      chk("lines_idle_after", int'({ps2_clk_oe, ps2_data_oe}), 0);
      chk("ack_err_held", ack_err, ack ? 0 : 1);
   endtask

   initial begin
      int n;
      int d0;
      cyc(3);
      chk("reset_outputs", int'({ps2_clk_oe, ps2_data_oe, busy, done, ack_err}), 0);
      rst = 1'b0;
      cyc(2);
      chk("idle_outputs", int'({ps2_clk_oe, ps2_data_oe, busy, done, ack_err}), 0);

      run_frame(8'hED, 1'b1, 1'b1, 1'b0, -1);
      run_frame(8'h00, 1'b1, 1'b0, 1'b1, -1);
      run_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1);
      run_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
      for (int k = 0; k < 4; k++)
         run_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
      run_frame(8'($urandom), 1'b0, 1'b0, 1'b0, -1);

      // Device that never clocks.
      d0 = done_cnt;
      start_tx(8'hA5);
      n = 0;
      while (!done && n < TMO + 100) begin
         n++;
         cyc(1);
      end
      chk("timeout_cycles", n, TMO);
      chk("timeout_ack_err", ack_err, 1);
      cyc(1);
      chk("timeout_lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
      chk("timeout_busy", busy, 0);
      chk("timeout_done_once", done_cnt - d0, 1);
      run_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);

      run_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 5);
      run_frame(8'hF4, 1'b1, 1'b0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
